// File: rtl/phy_pkg.sv
// Lane PHY constants and types shared by the transmit serialiser and the receiver.
package phy_pkg;

    localparam int         PHY_WIDTH      = 8;
    localparam logic [7:0] PHY_IDLE_SYM   = 8'hBC;
    localparam int         PHY_SYNC_COUNT = 4;

    // SYNC sends the comma burst after reset; ACTIVE carries payload.
    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

endpackage

// File: rtl/paralelo_serial_if.sv
// Parallel symbol handshake into the serialiser: source drives data/valid, sink returns ready.
interface paralelo_serial_if #(
    parameter int WIDTH = phy_pkg::PHY_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready;

    modport master (output data_in, output valid_in, input ready);
    modport slave  (input data_in, input valid_in, output ready);

endinterface

// File: rtl/phy_hold_reg.sv
// One-deep valid/ready holding register between the symbol source and the shifter.
module phy_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // Ready is forced low during reset so nothing is accepted while the lane is being cleared.
    assign ready = reset && !full;

    // Capture on a handshake; release when the shifter takes the symbol.
    // A push and a pop never coincide because ready is low whenever the register is full.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            full <= 1'b0;
        end else if (valid_in && ready) begin
            full <= 1'b1;
            data <= data_in;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Lane transmitter: serialises symbols MSB-first, one bit per clk_32f, idle/comma fill
// when nothing is queued, and a fixed comma burst after reset for receiver alignment.
module paralelo_serial
    import phy_pkg::*;
#(
    parameter int               WIDTH      = PHY_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(PHY_IDLE_SYM),
    parameter int               SYNC_COUNT = PHY_SYNC_COUNT
) (
    input  logic               clk_32f,
    input  logic               reset,
    paralelo_serial_if.slave   bus,
    output logic               data_out,
    output logic               symbol_start,
    output logic               data_sym,
    output logic               active
);

    localparam int BW  = $clog2(WIDTH);
    localparam int SCW = $clog2(SYNC_COUNT + 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [BW-1:0]    bit_cnt;
    logic [SCW-1:0]   sync_cnt;
    logic [WIDTH-1:0] cur_sym;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    logic             load;
    logic             sync_done;
    logic             take;
    logic             sync_inc;
    logic [WIDTH-1:0] sym_sel;

    phy_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .valid_in (bus.valid_in),
        .data_in  (bus.data_in),
        .pop      (take),
        .ready    (bus.ready),
        .full     (hold_full),
        .data     (hold_data)
    );

    // State register: SYNC after reset, ACTIVE until the next reset.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave SYNC on the load edge that follows the last comma of the burst.
    always_comb begin
        state_next = state;
        if (state == SYNC && load && sync_done) begin
            state_next = ACTIVE;
        end
    end

    // Symbol selection: the edge that ends SYNC already follows the ACTIVE rule,
    // so queued data goes out immediately after the burst.
    always_comb begin
        load      = (bit_cnt == '0);
        sync_done = (sync_cnt == SCW'(SYNC_COUNT));
        take      = 1'b0;
        sync_inc  = 1'b0;
        sym_sel   = IDLE_SYM;
        if (load) begin
            if (state == SYNC && !sync_done) begin
                sync_inc = 1'b1;
            end else if (hold_full) begin
                take    = 1'b1;
                sym_sel = hold_data;
            end
        end
    end

    // Shifter: load a new symbol when the last bit is on the line, otherwise step down one bit.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            cur_sym      <= '0;
            bit_cnt      <= '0;
            sync_cnt     <= '0;
            data_out     <= 1'b0;
            symbol_start <= 1'b0;
            data_sym     <= 1'b0;
            active       <= 1'b0;
        end else begin
            active <= (state_next == ACTIVE);
            if (sync_inc) begin
                sync_cnt <= sync_cnt + 1'b1;
            end
            if (load) begin
                cur_sym      <= sym_sel;
                data_out     <= sym_sel[WIDTH-1];
                bit_cnt      <= BW'(WIDTH - 1);
                symbol_start <= 1'b1;
                data_sym     <= take;
            end else begin
                data_out     <= cur_sym[bit_cnt - 1'b1];
                bit_cnt      <= bit_cnt - 1'b1;
                symbol_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: edge-counting reference model plus directed and random traffic.
module tb_paralelo_serial;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         LOGN = 256;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    logic data_out, symbol_start, data_sym, active;
    logic started = 1'b0;

    paralelo_serial_if #(.WIDTH(8)) bus ();

    paralelo_serial dut (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .bus          (bus),
        .data_out     (data_out),
        .symbol_start (symbol_start),
        .data_sym     (data_sym),
        .active       (active)
    );

    always #5 clk_32f = ~clk_32f;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release, holding slot, current symbol.
    int         m_k;
    int         ph;
    int         idx;
    bit         m_full;
    bit         pre_full;
    logic [7:0] m_hold;
    logic [7:0] m_sym;
    logic       e_do, e_ss, e_ds, e_act;

    logic lg_do  [0:LOGN-1];
    logic lg_ss  [0:LOGN-1];
    logic lg_ds  [0:LOGN-1];
    logic lg_act [0:LOGN-1];
    logic lg_rdy [0:LOGN-1];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] pack(input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = lg_do[s+i];
        return r;
    endfunction

    // Model: symbols start every 8 edges from edge 1; the first four are commas,
    // later ones carry the held byte if there is one, else a comma.
    always @(posedge clk_32f) begin
        if (!reset) begin
            m_k    = 0;
            m_full = 1'b0;
            e_do   = 1'b0;
            e_ss   = 1'b0;
            e_ds   = 1'b0;
            e_act  = 1'b0;
        end else begin
            ph       = m_k % 8;
            idx      = m_k / 8;
            pre_full = m_full;
            if (ph == 0) begin
                if (idx >= 4 && m_full) begin
                    m_sym  = m_hold;
                    e_ds   = 1'b1;
                    m_full = 1'b0;
                end else begin
                    m_sym = IDLE;
                    e_ds  = 1'b0;
                end
            end
            if (bus.valid_in && !pre_full) begin
                m_hold = bus.data_in;
                m_full = 1'b1;
            end
            e_do  = m_sym[7-ph];
            e_ss  = (ph == 0);
            e_act = (idx >= 4);
            m_k++;
        end
    end

    // Compare every cycle on the falling edge and log the first edges after each release.
    always @(negedge clk_32f) begin
        if (started) begin
            chk("data_out", {7'b0, data_out}, {7'b0, e_do});
            chk("symbol_start", {7'b0, symbol_start}, {7'b0, e_ss});
            chk("data_sym", {7'b0, data_sym}, {7'b0, e_ds});
            chk("active", {7'b0, active}, {7'b0, e_act});
            chk("ready", {7'b0, bus.ready}, {7'b0, reset && !m_full});
            if (reset && m_k < LOGN) begin
                lg_do[m_k]  = data_out;
                lg_ss[m_k]  = symbol_start;
                lg_ds[m_k]  = data_sym;
                lg_act[m_k] = active;
                lg_rdy[m_k] = bus.ready;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        logic r;
        int   n;
        bus.valid_in = 1'b1;
        bus.data_in  = b;
        n = 0;
        do begin
            @(negedge clk_32f);
            r = bus.ready;
            @(posedge clk_32f);
            #1;
            n++;
        end while (!r && n < 200);
        chk("send_accepted", {7'b0, r}, 8'h01);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_32f);
        #1;
    endtask

    initial begin
        int n;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        reset        = 1'b0;
        @(posedge clk_32f);
        #1 started = 1'b1;
        wait_edges(2);
        reset = 1'b1;

        // Idle burst plus one byte offered during SYNC.
        wait_edges(1);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        wait_edges(1);
        bus.valid_in = 1'b0;
        wait_edges(48);
        chk("idle_sym_e1", pack(1), IDLE);
        chk("idle_sym_e25", pack(25), IDLE);
        chk("a5_sym_e33", pack(33), 8'hA5);
        chk("idle_sym_e41", pack(41), IDLE);
        chk("ss_e1", {7'b0, lg_ss[1]}, 8'h01);
        chk("ss_e2", {7'b0, lg_ss[2]}, 8'h00);
        chk("ss_e9", {7'b0, lg_ss[9]}, 8'h01);
        chk("act_e32", {7'b0, lg_act[32]}, 8'h00);
        chk("act_e33", {7'b0, lg_act[33]}, 8'h01);
        chk("ds_e32", {7'b0, lg_ds[32]}, 8'h00);
        chk("ds_e33", {7'b0, lg_ds[33]}, 8'h01);
        chk("ds_e40", {7'b0, lg_ds[40]}, 8'h01);
        chk("ds_e41", {7'b0, lg_ds[41]}, 8'h00);
        chk("rdy_e2", {7'b0, lg_rdy[2]}, 8'h00);
        chk("rdy_e32", {7'b0, lg_rdy[32]}, 8'h00);
        chk("rdy_e41", {7'b0, lg_rdy[41]}, 8'h01);

        // Back-to-back stream.
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        // Data change while ready is low.
        send(8'h11);
        send(8'h22);
        // Data equal to the comma.
        send(IDLE);
        bus.valid_in = 1'b0;
        wait_edges(24);

        // Reset in the middle of a data symbol with a byte still held.
        send(8'h5A);
        send(8'h77);
        bus.valid_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk_32f);
            n++;
        end while (!(data_sym && symbol_start) && n < 100);
        chk("found_data_start", {7'b0, data_sym && symbol_start}, 8'h01);
        wait_edges(3);
        reset = 1'b0;
        wait_edges(1);
        reset = 1'b1;
        wait_edges(44);
        chk("rst_idle_e1", pack(1), IDLE);
        chk("rst_act_e32", {7'b0, lg_act[32]}, 8'h00);
        chk("rst_act_e33", {7'b0, lg_act[33]}, 8'h01);
        chk("rst_sym_e33", pack(33), IDLE);
        chk("rst_ds_e33", {7'b0, lg_ds[33]}, 8'h00);

        // Random traffic with occasional resets.
        repeat (3000) begin
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.data_in  = 8'($urandom);
            reset        = ($urandom_range(0, 599) != 0);
            wait_edges(1);
        end
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        wait_edges(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
